// File: rtl/gpio_controller.sv
// GPIO controller on a simple strobe-based IO bus.
// Holds an output register and reads debounced inputs. Each input can raise a
// sticky interrupt-status bit on a selectable edge. Status bits are cleared by
// writing a 1 to them; the interrupt line is the registered OR of enabled
// status bits.
//
// Bus semantics: io_write_en and io_read_en are single-cycle strobes with no
// backpressure (the block is always ready). A write is taken on the rising
// edge where io_write_en=1 and io_address hits a writable register. A read
// samples the addressed register on the edge where io_read_en=1 and presents
// it on io_read_data after that edge. io_read_data then holds until the next
// read.
module gpio_controller #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h280,
  parameter int          NUM_INPUTS      = 4,
  parameter int          NUM_OUTPUTS     = 18,
  parameter int          DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_write_en,
  input  logic                   io_read_en,
  input  logic [31:0]            io_address,
  input  logic [31:0]            io_write_data,
  output logic [31:0]            io_read_data,
  input  logic [NUM_INPUTS-1:0]  gpio_in,
  output logic [NUM_OUTPUTS-1:0] gpio_out,
  output logic                   gpio_interrupt
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [31:0] ADDR_OUT      = BASE_ADDRESS;
  localparam logic [31:0] ADDR_IN       = BASE_ADDRESS + 32'h4;
  localparam logic [31:0] ADDR_INT_EN   = BASE_ADDRESS + 32'h8;
  localparam logic [31:0] ADDR_INT_STAT = BASE_ADDRESS + 32'hC;
  localparam logic [31:0] ADDR_EDGE_SEL = BASE_ADDRESS + 32'h10;

  // Architectural registers
  logic [NUM_OUTPUTS-1:0] out_reg;
  logic [NUM_INPUTS-1:0]  int_en;
  logic [NUM_INPUTS-1:0]  int_status;
  logic [NUM_INPUTS-1:0]  edge_sel;

  // Input path: two-flop synchronizer, then per-pin debounce
  logic [NUM_INPUTS-1:0]  sync1;
  logic [NUM_INPUTS-1:0]  sync2;
  logic [NUM_INPUTS-1:0]  debounced;
  logic [CNT_W-1:0]       cnt [NUM_INPUTS];

  // Decoded strobes and derived vectors
  logic                   wr_out;
  logic                   wr_int_en;
  logic                   wr_int_stat;
  logic                   wr_edge_sel;
  logic [NUM_INPUTS-1:0]  w1c_mask;
  logic [NUM_INPUTS-1:0]  accept;
  logic [NUM_INPUTS-1:0]  edge_hit;
  logic [31:0]            rd_value;

  // Write decode: a write needs the write strobe and an exact address hit.
  always_comb begin
    wr_out      = io_write_en && (io_address == ADDR_OUT);
    wr_int_en   = io_write_en && (io_address == ADDR_INT_EN);
    wr_int_stat = io_write_en && (io_address == ADDR_INT_STAT);
    wr_edge_sel = io_write_en && (io_address == ADDR_EDGE_SEL);
    w1c_mask    = wr_int_stat ? io_write_data[NUM_INPUTS-1:0] : '0;
  end

  // Debounce acceptance and edge qualification. A pin is accepted on the edge
  // where it has differed from its debounced value long enough. The edge
  // direction equals the new value: 1 for rising, 0 for falling. It counts as
  // a hit when it matches the EDGE_SEL bit.
  always_comb begin
    accept   = '0;
    edge_hit = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      accept[i]   = (sync2[i] != debounced[i]) && (cnt[i] == CNT_LAST);
      edge_hit[i] = accept[i] && (sync2[i] == edge_sel[i]);
    end
  end

  // Read mux: registers are zero-extended; unmapped addresses return 0.
  always_comb begin
    rd_value = '0;
    case (io_address)
      ADDR_OUT:      rd_value[NUM_OUTPUTS-1:0] = out_reg;
      ADDR_IN:       rd_value[NUM_INPUTS-1:0]  = debounced;
      ADDR_INT_EN:   rd_value[NUM_INPUTS-1:0]  = int_en;
      ADDR_INT_STAT: rd_value[NUM_INPUTS-1:0]  = int_status;
      ADDR_EDGE_SEL: rd_value[NUM_INPUTS-1:0]  = edge_sel;
      default:       rd_value = '0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  // Per-pin debounce counters. A counter clears while the pin agrees with its
  // debounced value. Otherwise it counts up until acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debounced <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (sync2[i] == debounced[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          debounced[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Software-written control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg  <= '0;
      int_en   <= '0;
      edge_sel <= '1;
    end else begin
      if (wr_out)      out_reg  <= io_write_data[NUM_OUTPUTS-1:0];
      if (wr_int_en)   int_en   <= io_write_data[NUM_INPUTS-1:0];
      if (wr_edge_sel) edge_sel <= io_write_data[NUM_INPUTS-1:0];
    end
  end

  // Sticky status. Write-1-to-clear, but a same-cycle edge wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_status <= '0;
    end else begin
      int_status <= (int_status & ~w1c_mask) | edge_hit;
    end
  end

  // Registered interrupt line and read data; read data holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_interrupt <= 1'b0;
      io_read_data   <= '0;
    end else begin
      gpio_interrupt <= |(int_status & int_en);
      if (io_read_en) io_read_data <= rd_value;
    end
  end

  assign gpio_out = out_reg;

endmodule
